// File: rtl/tt_um_islam_ihfaz_latch_bank.sv
// Multi-word storage bank with synchronised enable strobe and four write modes
// (level latch, edge capture, toggle, shift), plus a wrapping write-event counter.
module tt_um_islam_ihfaz_latch_bank #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    MODE_LATCH  = 2'b00,
    MODE_EDGE   = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_SHIFT  = 2'b11
  } mode_t;

  logic [WIDTH-1:0] d;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic             e;
  logic             clr;
  mode_t            mode;

  assign d     = ui_in[WIDTH-1:0];
  assign waddr = ui_in[4 +: AW];
  assign e     = ui_in[6];
  assign mode  = mode_t'(uio_in[1:0]);
  assign raddr = uio_in[2 +: AW];
  assign clr   = uio_in[4];

  logic e_s;
  logic e_prev;
  logic rise;

  // Enable synchroniser: oldest sample sits in the MSB
  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_p;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_p <= '0;
        else        sync_p <= (sync_p << 1) | SYNC_STAGES'(e);
      end
      assign e_s = sync_p[SYNC_STAGES-1];
    end else begin : g_raw
      assign e_s = e;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) e_prev <= 1'b0;
    else        e_prev <= e_s;
  end

  assign rise = e_s & ~e_prev;

  logic [DEPTH-1:0][WIDTH-1:0] word_q;
  logic [DEPTH-1:0][WIDTH-1:0] word_nxt;
  logic                        accept;
  logic [2:0]                  evcnt;

  always_comb begin
    word_nxt = word_q;
    accept   = 1'b0;
    case (mode)
      MODE_LATCH: begin
        if (e_s) begin
          word_nxt[waddr] = d;
          accept          = 1'b1;
        end
      end
      MODE_EDGE: begin
        if (rise) begin
          word_nxt[waddr] = d;
          accept          = 1'b1;
        end
      end
      MODE_TOGGLE: begin
        if (rise) begin
          word_nxt[waddr] = word_q[waddr] ^ d;
          accept          = 1'b1;
        end
      end
      MODE_SHIFT: begin
        if (rise) begin
          for (int i = DEPTH - 1; i > 0; i--) word_nxt[i] = word_q[i-1];
          word_nxt[0] = d;
          accept      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Storage and event counter; clear wins over any same-cycle write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      evcnt  <= 3'd0;
    end else if (clr) begin
      word_q <= '0;
      evcnt  <= 3'd0;
    end else begin
      word_q <= word_nxt;
      if (accept) evcnt <= evcnt + 3'd1;
    end
  end

  logic [3:0] rd_word;

  always_comb begin
    rd_word             = 4'h0;
    rd_word[WIDTH-1:0]  = word_q[raddr];
  end

  assign uo_out  = {e_s, evcnt, rd_word};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in, uio_in};

endmodule
